// File: rtl/mpy_rr_scheduler.sv
// mpy_rr_scheduler: round-robin sharing of one iterative 32x32 multiplier among NREQ requesters.
// Optional macro MPY_TIMEOUT_EN aborts a WAIT that lasts TIMEOUT cycles with rsp_err=1.
module mpy_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 40
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [63:0]        rsp_product,
  output logic               rsp_err,
  output logic               mul_start,
  output logic [31:0]        mul_a,
  output logic [31:0]        mul_b,
  input  logic               mul_done,
  input  logic [63:0]        mul_product,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t         r_state;
  logic [IDW-1:0] r_ptr, r_id, w_gnt, w_idx;
  logic           w_any;
  logic [31:0]    r_a, r_b;
  logic [63:0]    r_p;
  // Scan downward so the last hit is the one closest after r_ptr.
  always_comb begin
    w_gnt = r_ptr;
    w_any = 1'b0;
    w_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IDW'((32'(r_ptr) + 32'(k)) % 32'(NREQ));
      if (req_valid[w_idx]) begin
        w_gnt = w_idx;
        w_any = 1'b1;
      end
    end
  end
  assign req_ready   = (r_state == IDLE && w_any && RST_N) ? NREQ'(1) << w_gnt : '0;
  assign busy        = r_state != IDLE;
  assign mul_start   = r_state == ISSUE;
  assign mul_a       = (r_state == ISSUE || r_state == WAIT) ? r_a : '0;
  assign mul_b       = (r_state == ISSUE || r_state == WAIT) ? r_b : '0;
  assign rsp_valid   = r_state == RESP;
  assign rsp_id      = rsp_valid ? r_id : '0;
  assign rsp_product = rsp_valid ? r_p : '0;
`ifdef MPY_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  assign rsp_err = rsp_valid & r_err;
`else
  assign rsp_err = 1'b0;
`endif
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_ptr   <= IDW'(NREQ - 1);
      r_id    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
`ifdef MPY_TIMEOUT_EN
      r_cnt   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_a     <= req_a[{w_gnt, 5'd0} +: 32];
          r_b     <= req_b[{w_gnt, 5'd0} +: 32];
          r_id    <= w_gnt;
          r_ptr   <= w_gnt;
          r_state <= ISSUE;
        end
        ISSUE: begin
          r_state <= WAIT;
`ifdef MPY_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        WAIT: if (mul_done) begin
          r_p     <= mul_product;
          r_state <= RESP;
`ifdef MPY_TIMEOUT_EN
          r_err   <= 1'b0;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          r_p     <= '0;
          r_err   <= 1'b1;
          r_state <= RESP;
        end else begin
          r_cnt   <= r_cnt + 1'b1;
`endif
        end
        RESP: if (rsp_ready) r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mpy_rr_scheduler.sv
// tb_mpy_rr_scheduler: randomized checks of the shared-multiplier scheduler against a behavioural model.
module tb_mpy_rr_scheduler;
  localparam int NREQ = 4, IDW = 2, TIMEOUT = 40;
  logic CLK = 1'b0, RST_N = 1'b0;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [NREQ*32-1:0] req_a, req_b;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err, mul_start, mul_done, busy;
  logic [IDW-1:0] rsp_id;
  logic [63:0] rsp_product, mul_product;
  logic [31:0] mul_a, mul_b;
  logic [31:0] op_a [NREQ], op_b [NREQ];
  logic mdl_done = 1'b0, tb_done = 1'b0, mdl_en = 1'b1;
  int mdl_lat = 5, mdl_cnt = 0, mdl_last = NREQ - 1;
  logic [31:0] mdl_a, mdl_b;
  int n_cmp = 0, n_bad = 0;

  always #5 CLK = ~CLK;
  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_a[32*g +: 32] = op_a[g];
    assign req_b[32*g +: 32] = op_b[g];
  end
  assign mul_done = mdl_done | tb_done;
  assign mul_product = {32'd0, mdl_a} * {32'd0, mdl_b};

  mpy_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done),
    .mul_product(mul_product), .busy(busy));

  // External multiplier: done pulses mdl_lat cycles after the start cycle.
  initial forever begin
    @(negedge CLK);
    mdl_done = 1'b0;
    if (!RST_N) mdl_cnt = 0;
    else begin
      if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0 && mdl_en) mdl_done = 1'b1;
      end
      if (mul_start) begin
        mdl_cnt = mdl_lat;
        mdl_a = mul_a;
        mdl_b = mul_b;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int exp_grant(input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++)
      if (m[(mdl_last + k) % NREQ]) return (mdl_last + k) % NREQ;
    return 0;
  endfunction

  task automatic expect_txn(input int id, input int lat, input int hold, input bit drop);
    int n, extra;
    logic [31:0] ea, eb;
    logic [63:0] ep;
    ea = op_a[id];
    eb = op_b[id];
    ep = {32'd0, ea} * {32'd0, eb};
    mdl_lat = lat;
    #1;
    n = 0;
    while (req_ready == '0 && n < 40) begin @(negedge CLK); n++; end
    n_cmp++;
    if (req_ready !== NREQ'(1 << id)) begin
      n_bad++; $display("FAIL grant: req_ready=%b expected %b", req_ready, NREQ'(1 << id));
    end
    mdl_last = id;
    @(negedge CLK);
    n_cmp++;
    if ({mul_start, busy, req_ready, mul_a, mul_b} !== {1'b1, 1'b1, NREQ'(0), ea, eb}) begin
      n_bad++; $display("FAIL issue: start=%b busy=%b ready=%b a=%h b=%h expected 1 1 0 %h %h",
                        mul_start, busy, req_ready, mul_a, mul_b, ea, eb);
    end
    if (drop) req_valid = '0;
    n = 0;
    extra = 0;
    do begin
      @(negedge CLK);
      n++;
      if (mul_start || req_ready != '0) extra++;
    end while (!rsp_valid && n < lat + 10);
    n_cmp++;
    if (n != lat + 1 || extra != 0) begin
      n_bad++; $display("FAIL latency: rsp after %0d cycles with %0d stray starts/readies, expected %0d and 0", n, extra, lat + 1);
    end
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_product} !== {1'b1, IDW'(id), 1'b0, ep}) begin
      n_bad++; $display("FAIL response: valid=%b id=%0d err=%b prod=%h expected 1 %0d 0 %h",
                        rsp_valid, rsp_id, rsp_err, rsp_product, id, ep);
    end
    repeat (hold) begin
      @(negedge CLK);
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_product, req_ready, mul_start} !== {1'b1, IDW'(id), ep, NREQ'(0), 1'b0}) begin
        n_bad++; $display("FAIL hold: valid=%b id=%0d prod=%h ready=%b start=%b expected 1 %0d %h 0 0",
                          rsp_valid, rsp_id, rsp_product, req_ready, mul_start, id, ep);
      end
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_bad++; $display("FAIL release: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_reset;
    @(negedge CLK);
    req_valid = '1;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_id, rsp_product, rsp_err, mul_start, mul_a, mul_b, busy} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: ready=%b rsp=%b id=%0d prod=%h err=%b start=%b a=%h b=%h busy=%b expected all 0",
                        req_ready, rsp_valid, rsp_id, rsp_product, rsp_err, mul_start, mul_a, mul_b, busy);
    end
    req_valid = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    mdl_last = NREQ - 1;
    @(negedge CLK);
    n_cmp++;
    if ({busy, req_ready, mul_start} !== '0) begin
      n_bad++; $display("FAIL idle_after_reset: busy=%b ready=%b start=%b expected 0", busy, req_ready, mul_start);
    end
  endtask

  task automatic test_single;
    op_a[0] = 32'd3;
    op_b[0] = 32'd5;
    req_valid = 4'b0001;
    expect_txn(0, 33, 0, 1'b1);
  endtask

  task automatic test_max;
    op_a[2] = 32'hFFFF_FFFF;
    op_b[2] = 32'hFFFF_FFFF;
    req_valid = 4'b0100;
    expect_txn(2, 7, 1, 1'b1);
  endtask

  task automatic test_all_rr;
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    mdl_last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = $urandom;
      op_b[i] = $urandom;
    end
    req_valid = '1;
    for (int i = 0; i <= NREQ; i++) expect_txn(i % NREQ, $urandom_range(1, 6), 0, 1'b0);
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    req_valid = 4'b1011;
    expect_txn(exp_grant(req_valid), 4, 10, 1'b0);
    req_valid = '0;
  endtask

  task automatic test_reset_mid;
    int seen;
    op_a[2] = $urandom;
    op_b[2] = $urandom;
    mdl_lat = 20;
    req_valid = 4'b0100;
    repeat (4) @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_id, rsp_product, rsp_err, mul_start, mul_a, mul_b, busy} !== '0) begin
      n_bad++; $display("FAIL async_reset: busy=%b a=%h b=%h start=%b rsp=%b expected all 0", busy, mul_a, mul_b, mul_start, rsp_valid);
    end
    req_valid = '0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    mdl_last = NREQ - 1;
    seen = 0;
    repeat (30) begin
      @(negedge CLK);
      if (rsp_valid || busy || mul_start) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++; $display("FAIL abandoned_op: %0d active cycles after reset, expected 0", seen);
    end
    req_valid = '1;
    expect_txn(0, 3, 0, 1'b1);
  endtask

  task automatic test_random;
    logic [NREQ-1:0] m;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        op_a[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        op_b[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      end
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      req_valid = m;
      expect_txn(exp_grant(m), $urandom_range(1, 8), $urandom_range(0, 3), 1'b1);
    end
  endtask

`ifdef MPY_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    mdl_en = 1'b0;
    op_a[1] = 32'd9;
    op_b[1] = 32'd11;
    mdl_lat = 5;
    req_valid = 4'b0010;
    #1;
    n = 0;
    while (!mul_start && n < 40) begin @(negedge CLK); n++; end
    req_valid = '0;
    mdl_last = 1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!rsp_valid && n < TIMEOUT + 10);
    n_cmp++;
    if (n != TIMEOUT + 1) begin
      n_bad++; $display("FAIL timeout_latency: rsp after %0d cycles, expected %0d", n, TIMEOUT + 1);
    end
    tb_done = 1'b1;
    @(negedge CLK);
    tb_done = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_id, rsp_product} !== {1'b1, 1'b1, IDW'(1), 64'd0}) begin
      n_bad++; $display("FAIL timeout_rsp: valid=%b err=%b id=%0d prod=%h expected 1 1 1 0", rsp_valid, rsp_err, rsp_id, rsp_product);
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    tb_done = 1'b1;
    @(negedge CLK);
    tb_done = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_bad++; $display("FAIL stray_done: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
    end
    mdl_en = 1'b1;
    req_valid = 4'b0010;
    expect_txn(1, 3, 0, 1'b1);
  endtask
`endif

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    test_reset;
    test_single;
    test_max;
    test_all_rr;
    test_backpressure;
    test_reset_mid;
    test_random;
`ifdef MPY_TIMEOUT_EN
    test_timeout;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
